// File: rtl/fifo_ext.sv
// Parametrised single-clock FIFO with guarded accept, sticky error flags,
// programmable almost-full/empty thresholds, synchronous flush and optional FWFT read.
module fifo_ext #(
    parameter int unsigned FIFO_WIDTH = 14,
    parameter int unsigned FIFO_DEPTH = 64,
    parameter int unsigned FWFT       = 0,
    parameter int unsigned AE_THRESH  = FIFO_DEPTH / 2,
    parameter int unsigned AF_THRESH  = FIFO_DEPTH - 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          wr_en,
    input  logic [FIFO_WIDTH-1:0]         wr_data,
    output logic                          fifo_full,
    output logic                          fifo_almst_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    input  logic                          rd_en,
    output logic [FIFO_WIDTH-1:0]         rd_data,
    output logic                          rd_valid,
    output logic                          fifo_empty,
    output logic                          fifo_almst_empty,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_nxt;
    logic                  wr_acc;
    logic                  rd_acc;

    // Status flags are pure decodes of the registered occupancy.
    assign fifo_full        = (count == CW'(FIFO_DEPTH));
    assign fifo_empty       = (count == '0);
    assign fifo_almst_full  = (count >= CW'(AF_THRESH));
    assign fifo_almst_empty = (count <  CW'(AE_THRESH));
    assign fifo_count       = count;

    assign wr_acc = wr_en & ~fifo_full;
    assign rd_acc = rd_en & ~fifo_empty;

    always_comb begin
        count_nxt = count + CW'(wr_acc) - CW'(rd_acc);
    end

    // Pointers, occupancy and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_nxt;
            if (wr_en & fifo_full) begin
                overflow <= 1'b1;
            end
            if (rd_en & fifo_empty) begin
                underflow <= 1'b1;
            end
        end
    end

    // Storage array is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_acc && !flush) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign rd_data  = mem[rd_ptr];
            assign rd_valid = ~fifo_empty;
        end else begin : g_std
            logic [FIFO_WIDTH-1:0] rd_data_q;
            logic                  rd_valid_q;

            // Registered read: data and a one-cycle valid pulse follow each accepted read.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else if (flush) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_acc;
                    if (rd_acc) begin
                        rd_data_q <= mem[rd_ptr];
                    end
                end
            end

            assign rd_data  = rd_data_q;
            assign rd_valid = rd_valid_q;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_ext.sv
// Bench for fifo_ext: a default standard-read instance and an 8-deep FWFT instance,
// each checked against a queue-based model of the FIFO.
module tb_fifo_ext;

    localparam int W = 14;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         flush0, wr_en0, rd_en0;
    logic [W-1:0] wr_data0, rd_data0;
    logic         full0, af0, empty0, ae0, rd_valid0, ovf0, udf0;
    logic [6:0]   count0;

    logic         flush1, wr_en1, rd_en1;
    logic [W-1:0] wr_data1, rd_data1;
    logic         full1, af1, empty1, ae1, rd_valid1, ovf1, udf1;
    logic [3:0]   count1;

    fifo_ext #(.FIFO_WIDTH(W), .FIFO_DEPTH(64), .FWFT(0)) u_std (
        .clk(clk), .rst_n(rst_n), .flush(flush0), .wr_en(wr_en0), .wr_data(wr_data0),
        .fifo_full(full0), .fifo_almst_full(af0), .fifo_count(count0), .rd_en(rd_en0),
        .rd_data(rd_data0), .rd_valid(rd_valid0), .fifo_empty(empty0),
        .fifo_almst_empty(ae0), .overflow(ovf0), .underflow(udf0)
    );

    fifo_ext #(.FIFO_WIDTH(W), .FIFO_DEPTH(8), .FWFT(1), .AE_THRESH(4), .AF_THRESH(4)) u_fwft (
        .clk(clk), .rst_n(rst_n), .flush(flush1), .wr_en(wr_en1), .wr_data(wr_data1),
        .fifo_full(full1), .fifo_almst_full(af1), .fifo_count(count1), .rd_en(rd_en1),
        .rd_data(rd_data1), .rd_valid(rd_valid1), .fifo_empty(empty1),
        .fifo_almst_empty(ae1), .overflow(ovf1), .underflow(udf1)
    );

    // Reference model: one queue plus sticky flags per instance.
    logic [W-1:0] mq [2][$];
    bit           mov [2];
    bit           mud [2];
    bit           mrv [2];
    logic [W-1:0] mrd [2];
    int           mdepth [2] = '{64, 8};

    int n_cmp = 0;
    int n_fail = 0;

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mq[d].delete();
            mov[d] = 1'b0;
            mud[d] = 1'b0;
            mrv[d] = 1'b0;
            mrd[d] = '0;
        end
    endtask

    task automatic cyc(input int d, input bit we, input logic [W-1:0] wd, input bit re, input bit fl);
        bit full, empty, wacc, racc;
        if (d == 0) begin
            wr_en0 = we; wr_data0 = wd; rd_en0 = re; flush0 = fl;
        end else begin
            wr_en1 = we; wr_data1 = wd; rd_en1 = re; flush1 = fl;
        end
        @(posedge clk);
        full  = (mq[d].size() == mdepth[d]);
        empty = (mq[d].size() == 0);
        if (fl) begin
            mq[d].delete();
            mov[d] = 1'b0;
            mud[d] = 1'b0;
            mrv[d] = 1'b0;
            mrd[d] = '0;
        end else begin
            wacc = we && !full;
            racc = re && !empty;
            if (we && full)  mov[d] = 1'b1;
            if (re && empty) mud[d] = 1'b1;
            mrv[d] = racc;
            if (racc) mrd[d] = mq[d].pop_front();
            if (wacc) mq[d].push_back(wd);
        end
        #1;
        wr_en0 = 1'b0; rd_en0 = 1'b0; flush0 = 1'b0;
        wr_en1 = 1'b0; rd_en1 = 1'b0; flush1 = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++; if (count0 !== 7'd0)  begin n_fail++; $display("FAIL reset_count: got %0d want 0", count0); end
        n_cmp++; if (empty0 !== 1'b1)  begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty0); end
        n_cmp++; if (full0 !== 1'b0)   begin n_fail++; $display("FAIL reset_full: got %b want 0", full0); end
        n_cmp++; if (ae0 !== 1'b1)     begin n_fail++; $display("FAIL reset_almst_empty: got %b want 1", ae0); end
        n_cmp++; if (af0 !== 1'b0)     begin n_fail++; $display("FAIL reset_almst_full: got %b want 0", af0); end
        n_cmp++; if ({ovf0, udf0, rd_valid0} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {ovf0, udf0, rd_valid0}); end
        n_cmp++; if (rd_data0 !== '0)  begin n_fail++; $display("FAIL reset_rd_data: got %h want 0", rd_data0); end
        n_cmp++; if ({empty1, rd_valid1, count1} !== 6'b10_0000) begin n_fail++; $display("FAIL reset_fwft: got %b want 100000", {empty1, rd_valid1, count1}); end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 64; i++) begin
            cyc(0, 1'b1, W'(i), 1'b0, 1'b0);
            n_cmp++;
            if (count0 !== 7'(i)) begin n_fail++; $display("FAIL fill_count: got %0d want %0d", count0, i); end
            n_cmp++;
            if (af0 !== (i >= 60)) begin n_fail++; $display("FAIL fill_almst_full: count %0d got %b want %b", i, af0, (i >= 60)); end
            n_cmp++;
            if (full0 !== (i == 64)) begin n_fail++; $display("FAIL fill_full: count %0d got %b want %b", i, full0, (i == 64)); end
        end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 64; i++) begin
            cyc(0, 1'b0, '0, 1'b1, 1'b0);
            n_cmp++;
            if (rd_valid0 !== 1'b1 || rd_data0 !== W'(i)) begin
                n_fail++; $display("FAIL drain_data: got v=%b %h want v=1 %h", rd_valid0, rd_data0, W'(i));
            end
            n_cmp++;
            if (ae0 !== ((64 - i) < 32)) begin n_fail++; $display("FAIL drain_almst_empty: count %0d got %b want %b", 64 - i, ae0, ((64 - i) < 32)); end
        end
        n_cmp++; if (empty0 !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %b want 1", empty0); end
        cyc(0, 1'b0, '0, 1'b0, 1'b0);
        n_cmp++;
        if (rd_valid0 !== 1'b0 || rd_data0 !== W'(64)) begin
            n_fail++; $display("FAIL drain_hold: got v=%b %h want v=0 0040", rd_valid0, rd_data0);
        end
    endtask

    task automatic test_full_rw();
        logic [W-1:0] head;
        for (int i = 0; i < 64; i++) cyc(0, 1'b1, W'($urandom), 1'b0, 1'b0);
        head = mq[0][0];
        cyc(0, 1'b1, 14'h3abc, 1'b1, 1'b0);
        n_cmp++; if (count0 !== 7'd63) begin n_fail++; $display("FAIL full_rw_count: got %0d want 63", count0); end
        n_cmp++; if (ovf0 !== 1'b1 || udf0 !== 1'b0) begin n_fail++; $display("FAIL full_rw_flags: got ovf=%b udf=%b want 1 0", ovf0, udf0); end
        n_cmp++; if (rd_data0 !== head || rd_valid0 !== 1'b1) begin n_fail++; $display("FAIL full_rw_head: got %h want %h", rd_data0, head); end
        // flush with both requests raised: requests must be ignored
        cyc(0, 1'b1, 14'h0055, 1'b1, 1'b1);
        n_cmp++;
        if ({count0, ovf0, udf0, rd_valid0, empty0} !== {7'd0, 4'b0001}) begin
            n_fail++; $display("FAIL flush_state: got cnt=%0d ovf=%b udf=%b v=%b e=%b", count0, ovf0, udf0, rd_valid0, empty0);
        end
        n_cmp++; if (rd_data0 !== '0) begin n_fail++; $display("FAIL flush_rd_data: got %h want 0", rd_data0); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++) cyc(0, 1'b1, W'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 50; i++) begin
            cyc(0, 1'b1, W'($urandom), 1'b1, 1'b0);
            n_cmp++;
            if (count0 !== 7'd10 || rd_valid0 !== 1'b1 || rd_data0 !== mrd[0]) begin
                n_fail++; $display("FAIL b2b: got cnt=%0d v=%b %h want 10 1 %h", count0, rd_valid0, rd_data0, mrd[0]);
            end
        end
        cyc(0, 1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic test_empty_rw();
        cyc(1, 1'b1, 14'h1234, 1'b1, 1'b0);
        n_cmp++; if (count1 !== 4'd1 || udf1 !== 1'b1) begin n_fail++; $display("FAIL empty_rw_fwft: got cnt=%0d udf=%b want 1 1", count1, udf1); end
        n_cmp++; if (rd_data1 !== 14'h1234 || rd_valid1 !== 1'b1) begin n_fail++; $display("FAIL empty_rw_fwft_data: got v=%b %h want 1 1234", rd_valid1, rd_data1); end
        cyc(0, 1'b1, 14'h1234, 1'b1, 1'b0);
        n_cmp++; if (count0 !== 7'd1 || udf0 !== 1'b1 || rd_valid0 !== 1'b0) begin
            n_fail++; $display("FAIL empty_rw_std: got cnt=%0d udf=%b v=%b want 1 1 0", count0, udf0, rd_valid0);
        end
        cyc(0, 1'b0, '0, 1'b0, 1'b1);
        cyc(1, 1'b0, '0, 1'b0, 1'b1);
        n_cmp++; if (udf1 !== 1'b0 || empty1 !== 1'b1) begin n_fail++; $display("FAIL empty_rw_flush: got udf=%b e=%b want 0 1", udf1, empty1); end
    endtask

    task automatic test_wrap();
        logic [W-1:0] sent[$];
        logic [W-1:0] wd, exp_w;
        bit we, re;
        int nw, nr, cycles, sz;
        nw = 0; nr = 0; cycles = 0;
        while ((nw < 200 || nr < 200) && cycles < 5000) begin
            sz = mq[1].size();
            we = (nw < 200) && (sz < 8) && ($urandom_range(0, 2) != 0);
            re = (sz > 0) && ($urandom_range(0, 2) != 0);
            wd = W'($urandom);
            if (re) begin
                exp_w = sent.pop_front();
                n_cmp++;
                if (rd_data1 !== exp_w) begin n_fail++; $display("FAIL wrap_order: word %0d got %h want %h", nr, rd_data1, exp_w); end
                nr++;
            end
            if (we) begin
                sent.push_back(wd);
                nw++;
            end
            cyc(1, we, wd, re, 1'b0);
            sz = mq[1].size();
            n_cmp++;
            if (count1 !== 4'(sz) || af1 !== (sz >= 4) || ae1 !== (sz < 4) || full1 !== (sz == 8) || rd_valid1 !== (sz != 0)) begin
                n_fail++; $display("FAIL wrap_status: got cnt=%0d af=%b ae=%b f=%b v=%b want cnt=%0d", count1, af1, ae1, full1, rd_valid1, sz);
            end
            cycles++;
        end
        n_cmp++; if (nr != 200) begin n_fail++; $display("FAIL wrap_timeout: got %0d reads want 200", nr); end
        n_cmp++; if (ovf1 !== 1'b0 || udf1 !== 1'b0) begin n_fail++; $display("FAIL wrap_errors: got ovf=%b udf=%b want 0 0", ovf1, udf1); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 18; i++) cyc(0, 1'b1, W'(16'h0100 + i), 1'b0, 1'b0);
        cyc(0, 1'b0, '0, 1'b1, 1'b0);
        n_cmp++; if (count0 !== 7'd17 || rd_data0 !== 14'h0100) begin n_fail++; $display("FAIL pre_reset: got cnt=%0d %h want 17 0100", count0, rd_data0); end
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_cmp++;
        if ({count0, empty0, full0, ae0, af0} !== {7'd0, 4'b1010}) begin
            n_fail++; $display("FAIL async_reset_status: got cnt=%0d e=%b f=%b ae=%b af=%b", count0, empty0, full0, ae0, af0);
        end
        n_cmp++;
        if ({ovf0, udf0, rd_valid0} !== 3'b000 || rd_data0 !== '0) begin
            n_fail++; $display("FAIL async_reset_read: got ovf=%b udf=%b v=%b %h", ovf0, udf0, rd_valid0, rd_data0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(0, 1'b1, 14'h002a, 1'b0, 1'b0);
        n_cmp++; if (count0 !== 7'd1) begin n_fail++; $display("FAIL post_reset_write: got cnt=%0d want 1", count0); end
    endtask

    initial begin
        rst_n = 1'b0;
        flush0 = 1'b0; wr_en0 = 1'b0; rd_en0 = 1'b0; wr_data0 = '0;
        flush1 = 1'b0; wr_en1 = 1'b0; rd_en1 = 1'b0; wr_data1 = '0;
        model_reset();
        #12;
        test_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        test_fill();
        test_drain();
        test_full_rw();
        test_back_to_back();
        test_empty_rw();
        test_wrap();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_ext.md
# fifo_ext

Parametrised single-clock FIFO, successor to the team's basic 14-bit × 64 buffer. It adds:

- guarded full/empty acceptance;
- a correctly sized occupancy counter;
- programmable almost-full/almost-empty thresholds;
- an optional first-word-fall-through read mode;
- sticky overflow/underflow error flags;
- a synchronous flush.

It sits between a sample producer and a downstream consumer in the same clock domain.

## Interface
- FIFO_WIDTH, 14, data word width in bits (≥1)
- FIFO_DEPTH, 64, number of entries; power of two, ≥4
- FWFT, 0, read mode: 0 = standard (registered read), 1 = first-word-fall-through
- AE_THRESH, FIFO_DEPTH/2, fifo_almst_empty asserted while count < AE_THRESH; legal range 1..FIFO_DEPTH-1
- AF_THRESH, FIFO_DEPTH-4, fifo_almst_full asserted while count ≥ AF_THRESH; legal range 1..FIFO_DEPTH
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of contents, count and error flags
- wr_en  in  1  write request
- wr_data  in  FIFO_WIDTH  write data
- fifo_full  out  1  count == FIFO_DEPTH
- fifo_almst_full  out  1  count ≥ AF_THRESH
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy, 0..FIFO_DEPTH
- rd_en  in  1  read request (FWFT=1: acknowledge of the word shown on rd_data)
- rd_data  out  FIFO_WIDTH  read data
- rd_valid  out  1  FWFT=0: one-cycle pulse, rd_data updated this cycle; FWFT=1: equals !fifo_empty
- fifo_empty  out  1  count == 0
- fifo_almst_empty  out  1  count < AE_THRESH
- overflow  out  1  sticky; a write was rejected
- underflow  out  1  sticky; a read was rejected

## Operation
- Acceptance:
  - wr_acc = wr_en & !fifo_full
  - rd_acc = rd_en & !fifo_empty
  - Both use the flags as they stand before the edge; there is no write-through when full.
- Count: next = count + wr_acc − rd_acc, computed at full $clog2(FIFO_DEPTH)+1 width. It never exceeds FIFO_DEPTH or goes below 0.
- Pointers: wr_ptr and rd_ptr are $clog2(FIFO_DEPTH) bits wide. Each increments on its accept and wraps FIFO_DEPTH−1 → 0 naturally.
- Memory: written at wr_ptr on wr_acc. Memory contents are not reset.
- FWFT=0:
  - On rd_acc, rd_data <= mem[rd_ptr] and rd_valid <= 1.
  - Otherwise rd_valid <= 0 and rd_data holds its value.
- FWFT=1:
  - rd_data = mem[rd_ptr] combinationally.
  - rd_data is meaningful only while fifo_empty=0; it is not checked while empty.
- Simultaneous events:
  - Full with wr_en & rd_en: the read is accepted, the write is rejected, overflow is set, and count goes to FIFO_DEPTH−1.
  - Empty with wr_en & rd_en: the write is accepted, the read is rejected, underflow is set, and count goes to 1.
  - Neither full nor empty with both requests: both are accepted and count is unchanged.
- Error flags: overflow sets on wr_en & fifo_full; underflow sets on rd_en & fifo_empty. Both hold until flush or reset.
- flush (highest priority after reset), at the next edge:
  - pointers, count, overflow, underflow and rd_valid go to 0;
  - rd_data goes to 0 in FWFT=0;
  - wr_en/rd_en in the same cycle are ignored and set no error flag.
- Status flags are pure decodes of the registered count. They carry no extra state.

## Timing
- Reset values:
  - fifo_count = 0; fifo_empty = 1; fifo_full = 0; fifo_almst_empty = 1; fifo_almst_full = 0.
  - overflow = 0; underflow = 0; rd_valid = 0; rd_data = 0 (FWFT=0).
- Reset is asynchronous. Asserting it mid-transfer discards all contents immediately. The first accept after rst_n deasserts happens on the following edge.
- Write at edge N: count and flags update after edge N. In FWFT=1 the word is visible on rd_data after edge N.
- FWFT=0 read accepted at edge N: rd_data and rd_valid valid after edge N (1-cycle latency). rd_valid falls after edge N+1 unless another read is accepted.
- FWFT=1 read accepted at edge N: rd_data shows the next word (or fifo_empty=1) after edge N.
- Sustained 1 write + 1 read per cycle is supported with count stable.

## Test plan
- Reset, then write 0x0001..0x0040 (64 words, default params) → fifo_full=1 and fifo_count=64 after the 64th edge; fifo_almst_full first asserts with count=60.
- Read all 64 words in FWFT=0 → rd_data sequence 0x0001..0x0040, each one cycle after its rd_en; fifo_empty=1 after the last read; almst_empty asserts at count=31.
- Full FIFO, drive wr_en=rd_en=1 for one cycle → count=63, overflow=1, head word returned, the new write is lost. Then flush → count=0 and overflow=0.
- Empty FIFO with wr_en=rd_en=1, wr_data=0x1234 → count=1, underflow=1. With FWFT=1, rd_data=0x1234 on the next cycle.
- Pointer wrap: 200 words streamed with random gaps at FIFO_DEPTH=8 → output order identical to input; no error flag set.
- Assert rst_n=0 mid-stream with count=17 → all outputs return to their reset values without waiting for a clock edge.
